// File: rtl/cmip_sync_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cmip_sync_pkt_fifo                                              |
// | Purpose  : Single-clock store-and-forward packet FIFO, FWFT output.        |
// |            Writes land speculatively at wr_ptr and become readable only    |
// |            once wr_cmt advances on an error-free EOP. Bad packets rewind   |
// |            wr_ptr to wr_cmt. With PKT_MODE=0 every write commits at once.  |
// | Ports    : i_clk/i_rst_n    clock, async active-low reset                  |
// |            i_wr/i_din/i_eop/i_err  write side                              |
// |            i_rd/o_dout/o_eop/o_empty  FWFT read side                       |
// |            o_full/o_aful/o_amty, o_used_cnt, o_pkt_cnt  status             |
// |            o_ovfl_int/o_unfl_int/o_drop_int  one-cycle event pulses        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cmip_sync_pkt_fifo #(
   parameter int DPTH         = 256,
   parameter int DATA_WDTH    = 32,
   parameter int ADDR_WDTH    = $clog2(DPTH),
   parameter int PKT_MODE     = 1,
   parameter int PKT_CNT_WDTH = ADDR_WDTH + 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [ADDR_WDTH:0]      i_aful_th,
   input  logic [ADDR_WDTH:0]      i_amty_th,
   input  logic                    i_wr,
   input  logic [DATA_WDTH-1:0]    i_din,
   input  logic                    i_eop,
   input  logic                    i_err,
   input  logic                    i_rd,
   output logic [DATA_WDTH-1:0]    o_dout,
   output logic                    o_eop,
   output logic                    o_empty,
   output logic                    o_full,
   output logic                    o_aful,
   output logic                    o_amty,
   output logic [ADDR_WDTH:0]      o_used_cnt,
   output logic [PKT_CNT_WDTH-1:0] o_pkt_cnt,
   output logic                    o_ovfl_int,
   output logic                    o_unfl_int,
   output logic                    o_drop_int
);

   localparam logic [ADDR_WDTH:0]      c_depth   = {1'b1, {ADDR_WDTH{1'b0}}};
   localparam logic [ADDR_WDTH:0]      c_ptr_one = {{ADDR_WDTH{1'b0}}, 1'b1};
   localparam logic [PKT_CNT_WDTH-1:0] c_cnt_one = {{(PKT_CNT_WDTH-1){1'b0}}, 1'b1};

   // storage holds {eop, data}
   logic [DATA_WDTH:0]      r_mem [DPTH];

   logic [ADDR_WDTH:0]      r_wr_ptr;   // speculative write pointer
   logic [ADDR_WDTH:0]      r_wr_cmt;   // committed write pointer
   logic [ADDR_WDTH:0]      r_rd_ptr;   // prefetch read pointer
   logic [ADDR_WDTH:0]      r_rd_pop;   // words actually popped by the consumer
   logic                    r_bad;      // current packet lost a word to overflow

   logic                    r_s1_vld;   // registered memory read stage
   logic [DATA_WDTH:0]      r_s1_data;
   logic                    r_out_vld;  // FWFT head register
   logic [DATA_WDTH-1:0]    r_dout;
   logic                    r_eop;

   logic [PKT_CNT_WDTH-1:0] r_pkt_cnt;
   logic                    r_ovfl_int;
   logic                    r_unfl_int;
   logic                    r_drop_int;

   logic [ADDR_WDTH:0]      w_total;
   logic [ADDR_WDTH:0]      w_used;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_unfl;
   logic                    w_ovfl;
   logic                    w_mem_we;
   logic                    w_out_ld;
   logic                    w_issue;
   logic [ADDR_WDTH:0]      w_wr_ptr_nxt;
   logic [ADDR_WDTH:0]      w_wr_cmt_nxt;
   logic                    w_bad_nxt;
   logic                    w_drop;
   logic                    w_pkt_inc;
   logic                    w_pkt_dec;
   logic [PKT_CNT_WDTH-1:0] w_pkt_cnt_nxt;

   // Fullness counts uncommitted words and only shrinks on pops, so a
   // prefetched-but-unpopped head word still occupies its slot.
   assign w_total = r_wr_ptr - r_rd_pop;
   assign w_used  = r_wr_cmt - r_rd_pop;
   assign w_full  = (w_total == c_depth);

   assign w_mem_we = i_wr & ~w_full;
   assign w_ovfl   = i_wr & w_full;

   assign w_pop  = i_rd & r_out_vld;
   assign w_unfl = i_rd & ~r_out_vld;

   // Two-stage prefetch: memory read register feeds the head register.
   // The read stage refills whenever it is empty or hands its word on,
   // which keeps one pop per cycle going without a bubble.
   assign w_out_ld = r_s1_vld & (~r_out_vld | w_pop);
   assign w_issue  = (r_rd_ptr != r_wr_cmt) & (~r_s1_vld | w_out_ld);

   assign w_pkt_dec = w_pop & r_eop;

   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_wr_cmt_nxt = r_wr_cmt;
      w_bad_nxt    = r_bad;
      w_drop       = 1'b0;
      w_pkt_inc    = 1'b0;
      if (PKT_MODE != 0) begin
         if (i_wr && i_eop) begin
            // An EOP that itself cannot be stored also loses the packet.
            if (i_err || r_bad || w_full) begin
               w_wr_ptr_nxt = r_wr_cmt;
               w_bad_nxt    = 1'b0;
               w_drop       = 1'b1;
            end else begin
               w_wr_ptr_nxt = r_wr_ptr + c_ptr_one;
               w_wr_cmt_nxt = r_wr_ptr + c_ptr_one;
               w_pkt_inc    = 1'b1;
            end
         end else if (i_wr) begin
            if (w_full) begin
               w_bad_nxt = 1'b1;
            end else begin
               w_wr_ptr_nxt = r_wr_ptr + c_ptr_one;
            end
         end
      end else begin
         if (w_mem_we) begin
            w_wr_ptr_nxt = r_wr_ptr + c_ptr_one;
            w_wr_cmt_nxt = r_wr_ptr + c_ptr_one;
            w_pkt_inc    = i_eop;
         end
      end
   end

   always_comb begin
      w_pkt_cnt_nxt = r_pkt_cnt;
      if (w_pkt_inc && !w_pkt_dec) begin
         w_pkt_cnt_nxt = r_pkt_cnt + c_cnt_one;
      end else if (!w_pkt_inc && w_pkt_dec) begin
         w_pkt_cnt_nxt = r_pkt_cnt - c_cnt_one;
      end
   end

   // Storage has no reset so it maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_mem[r_wr_ptr[ADDR_WDTH-1:0]] <= {i_eop, i_din};
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_issue) begin
         r_s1_data <= r_mem[r_rd_ptr[ADDR_WDTH-1:0]];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_wr_cmt   <= '0;
         r_rd_ptr   <= '0;
         r_rd_pop   <= '0;
         r_bad      <= 1'b0;
         r_s1_vld   <= 1'b0;
         r_out_vld  <= 1'b0;
         r_dout     <= '0;
         r_eop      <= 1'b0;
         r_pkt_cnt  <= '0;
         r_ovfl_int <= 1'b0;
         r_unfl_int <= 1'b0;
         r_drop_int <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_wr_cmt <= w_wr_cmt_nxt;
         r_bad    <= w_bad_nxt;
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_pop <= r_rd_pop + c_ptr_one;
         end
         if (w_issue) begin
            r_s1_vld <= 1'b1;
         end else if (w_out_ld) begin
            r_s1_vld <= 1'b0;
         end
         if (w_out_ld) begin
            r_out_vld <= 1'b1;
            r_dout    <= r_s1_data[DATA_WDTH-1:0];
            r_eop     <= r_s1_data[DATA_WDTH];
         end else if (w_pop) begin
            r_out_vld <= 1'b0;
         end
         r_pkt_cnt  <= w_pkt_cnt_nxt;
         r_ovfl_int <= w_ovfl;
         r_unfl_int <= w_unfl;
         r_drop_int <= w_drop;
      end
   end

   assign o_dout     = r_dout;
   assign o_eop      = r_eop;
   assign o_empty    = ~r_out_vld;
   assign o_full     = w_full;
   assign o_aful     = (w_total >= i_aful_th);
   assign o_amty     = (w_used <= i_amty_th);
   assign o_used_cnt = w_used;
   assign o_pkt_cnt  = r_pkt_cnt;
   assign o_ovfl_int = r_ovfl_int;
   assign o_unfl_int = r_unfl_int;
   assign o_drop_int = r_drop_int;

endmodule
`default_nettype wire

// File: tb/tb_cmip_sync_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cmip_sync_pkt_fifo                                           |
// | Purpose  : Directed self-checking bench. Instance a runs packet mode,      |
// |            instance b plain FWFT mode; both share stimulus, DPTH=8.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cmip_sync_pkt_fifo;

   localparam int DPTH = 8;
   localparam int DW   = 16;
   localparam int AW   = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW:0]   aful_th;
   logic [AW:0]   amty_th;
   logic          wr;
   logic [DW-1:0] din;
   logic          eop;
   logic          err;
   logic          rd;

   logic [DW-1:0] a_dout, b_dout;
   logic          a_eop, b_eop, a_empty, b_empty, a_full, b_full;
   logic          a_aful, b_aful, a_amty, b_amty;
   logic [AW:0]   a_used, b_used, a_pkt, b_pkt;
   logic          a_ovfl, b_ovfl, a_unfl, b_unfl, a_drop, b_drop;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cmip_sync_pkt_fifo #(.DPTH(DPTH), .DATA_WDTH(DW), .PKT_MODE(1)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_aful_th(aful_th), .i_amty_th(amty_th),
      .i_wr(wr), .i_din(din), .i_eop(eop), .i_err(err), .i_rd(rd),
      .o_dout(a_dout), .o_eop(a_eop), .o_empty(a_empty), .o_full(a_full),
      .o_aful(a_aful), .o_amty(a_amty), .o_used_cnt(a_used), .o_pkt_cnt(a_pkt),
      .o_ovfl_int(a_ovfl), .o_unfl_int(a_unfl), .o_drop_int(a_drop)
   );

   cmip_sync_pkt_fifo #(.DPTH(DPTH), .DATA_WDTH(DW), .PKT_MODE(0)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_aful_th(aful_th), .i_amty_th(amty_th),
      .i_wr(wr), .i_din(din), .i_eop(eop), .i_err(err), .i_rd(rd),
      .o_dout(b_dout), .o_eop(b_eop), .o_empty(b_empty), .o_full(b_full),
      .o_aful(b_aful), .o_amty(b_amty), .o_used_cnt(b_used), .o_pkt_cnt(b_pkt),
      .o_ovfl_int(b_ovfl), .o_unfl_int(b_unfl), .o_drop_int(b_drop)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_word(input logic [DW-1:0] d, input logic e, input logic r);
      wr  = 1'b1;
      din = d;
      eop = e;
      err = r;
      tick();
      wr  = 1'b0;
      eop = 1'b0;
      err = 1'b0;
   endtask

   task automatic do_reset();
      wr = 1'b0; din = '0; eop = 1'b0; err = 1'b0; rd = 1'b0;
      aful_th = 4'd6;
      amty_th = 4'd2;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%0b exp=1", a_empty); end
      checks++; if (a_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%0b exp=0", a_full); end
      checks++; if (a_amty !== 1'b1) begin failures++; $display("FAIL rst_amty got=%0b exp=1", a_amty); end
      checks++; if (a_aful !== 1'b0) begin failures++; $display("FAIL rst_aful got=%0b exp=0", a_aful); end
      checks++; if (a_used !== 4'd0 || a_pkt !== 4'd0) begin failures++; $display("FAIL rst_counts got used=%0d pkt=%0d exp=0/0", a_used, a_pkt); end
      checks++; if ({a_ovfl, a_unfl, a_drop} !== 3'b000) begin failures++; $display("FAIL rst_ints got=%b exp=000", {a_ovfl, a_unfl, a_drop}); end
      checks++; if (a_dout !== 16'h0 || a_eop !== 1'b0) begin failures++; $display("FAIL rst_dout got=%0h/%0b exp=0/0", a_dout, a_eop); end
      aful_th = 4'd0;
      #1;
      checks++; if (a_aful !== 1'b1) begin failures++; $display("FAIL rst_aful_th0 got=%0b exp=1", a_aful); end
      aful_th = 4'd6;
   endtask

   task automatic test_good_pkt();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         wr_word(16'(16'hA000 + k), (k == 3), 1'b0);
         checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL good_empty_w%0d got=%0b exp=1", k, a_empty); end
      end
      checks++; if (a_used !== 4'd4) begin failures++; $display("FAIL good_used got=%0d exp=4", a_used); end
      checks++; if (a_pkt !== 4'd1) begin failures++; $display("FAIL good_pkt got=%0d exp=1", a_pkt); end
      tick();
      checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL good_lat1 got=%0b exp=1", a_empty); end
      tick();
      checks++; if (a_empty !== 1'b0) begin failures++; $display("FAIL good_lat2 got=%0b exp=0", a_empty); end
      rd = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++; if (a_dout !== 16'(16'hA000 + k) || a_eop !== (k == 3) || a_empty !== 1'b0) begin
            failures++; $display("FAIL good_pop%0d got=%0h/%0b/%0b exp=%0h/%0b/0", k, a_dout, a_eop, a_empty, 16'(16'hA000 + k), (k == 3));
         end
         tick();
      end
      rd = 1'b0;
      checks++; if (a_empty !== 1'b1 || a_used !== 4'd0 || a_pkt !== 4'd0) begin
         failures++; $display("FAIL good_end got=%0b/%0d/%0d exp=1/0/0", a_empty, a_used, a_pkt);
      end
   endtask

   task automatic test_err_drop();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         wr_word(16'(16'hE000 + k), (k == 3), (k == 3));
      end
      checks++; if (a_drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%0b exp=1", a_drop); end
      checks++; if (b_drop !== 1'b0) begin failures++; $display("FAIL drop_plain got=%0b exp=0", b_drop); end
      tick();
      checks++; if (a_drop !== 1'b0) begin failures++; $display("FAIL drop_single got=%0b exp=0", a_drop); end
      tick();
      checks++; if (a_empty !== 1'b1 || a_used !== 4'd0) begin failures++; $display("FAIL drop_empty got=%0b/%0d exp=1/0", a_empty, a_used); end
      wr_word(16'h00A1, 1'b0, 1'b0);
      wr_word(16'h00A2, 1'b1, 1'b0);
      tick();
      tick();
      checks++; if (a_dout !== 16'h00A1 || a_empty !== 1'b0) begin failures++; $display("FAIL drop_next0 got=%0h/%0b exp=a1/0", a_dout, a_empty); end
      rd = 1'b1;
      tick();
      checks++; if (a_dout !== 16'h00A2 || a_eop !== 1'b1) begin failures++; $display("FAIL drop_next1 got=%0h/%0b exp=a2/1", a_dout, a_eop); end
      tick();
      rd = 1'b0;
      checks++; if (a_empty !== 1'b1 || a_pkt !== 4'd0) begin failures++; $display("FAIL drop_next_end got=%0b/%0d exp=1/0", a_empty, a_pkt); end
   endtask

   task automatic test_overflow();
      int ovfl_seen;
      do_reset();
      ovfl_seen = 0;
      for (int k = 0; k < 10; k++) begin
         wr_word(16'(16'h4000 + k), (k == 9), 1'b0);
         if (a_ovfl === 1'b1) ovfl_seen++;
         if (k == 6) begin
            checks++; if (a_full !== 1'b0) begin failures++; $display("FAIL ovf_full7 got=%0b exp=0", a_full); end
         end
         if (k == 7) begin
            checks++; if (a_full !== 1'b1 || a_ovfl !== 1'b0) begin failures++; $display("FAIL ovf_full8 got=%0b/%0b exp=1/0", a_full, a_ovfl); end
         end
      end
      checks++; if (a_drop !== 1'b1) begin failures++; $display("FAIL ovf_drop got=%0b exp=1", a_drop); end
      checks++; if (a_full !== 1'b0 || a_aful !== 1'b0 || a_used !== 4'd0) begin
         failures++; $display("FAIL ovf_rewind got=%0b/%0b/%0d exp=0/0/0", a_full, a_aful, a_used);
      end
      tick();
      if (a_ovfl === 1'b1) ovfl_seen++;
      checks++; if (ovfl_seen != 2) begin failures++; $display("FAIL ovf_pulses got=%0d exp=2", ovfl_seen); end
      wr_word(16'h0055, 1'b0, 1'b0);
      wr_word(16'h0056, 1'b1, 1'b0);
      tick();
      tick();
      checks++; if (a_dout !== 16'h0055 || a_empty !== 1'b0 || a_pkt !== 4'd1) begin
         failures++; $display("FAIL ovf_next got=%0h/%0b/%0d exp=55/0/1", a_dout, a_empty, a_pkt);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 5; k++) wr_word(16'(16'h1000 + k), (k == 4), 1'b0);
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         checks++; if (a_dout !== 16'(16'h1000 + k) || a_empty !== 1'b0 || a_pkt !== 4'd1) begin
            failures++; $display("FAIL b2b_p1_%0d got=%0h/%0b/%0d exp=%0h/0/1", k, a_dout, a_empty, a_pkt, 16'(16'h1000 + k));
         end
         wr = 1'b1; din = 16'(16'h2000 + k); eop = (k == 4); err = 1'b0; rd = 1'b1;
         tick();
      end
      wr = 1'b0; eop = 1'b0; rd = 1'b0;
      checks++; if (a_pkt !== 4'd1 || a_used !== 4'd5 || a_empty !== 1'b1) begin
         failures++; $display("FAIL b2b_commit_pop got=%0d/%0d/%0b exp=1/5/1", a_pkt, a_used, a_empty);
      end
      tick();
      checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL b2b_lat1 got=%0b exp=1", a_empty); end
      tick();
      rd = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++; if (a_dout !== 16'(16'h2000 + k) || a_eop !== (k == 4) || a_empty !== 1'b0) begin
            failures++; $display("FAIL b2b_p2_%0d got=%0h/%0b/%0b exp=%0h/%0b/0", k, a_dout, a_eop, a_empty, 16'(16'h2000 + k), (k == 4));
         end
         tick();
      end
      rd = 1'b0;
      checks++; if (a_pkt !== 4'd0 || a_used !== 4'd0 || a_empty !== 1'b1) begin
         failures++; $display("FAIL b2b_end got=%0d/%0d/%0b exp=0/0/1", a_pkt, a_used, a_empty);
      end
   endtask

   task automatic test_unfl_thresholds();
      do_reset();
      rd = 1'b1;
      tick();
      rd = 1'b0;
      checks++; if (a_unfl !== 1'b1 || b_unfl !== 1'b1) begin failures++; $display("FAIL unfl_pulse got=%0b/%0b exp=1/1", a_unfl, b_unfl); end
      tick();
      checks++; if (a_unfl !== 1'b0) begin failures++; $display("FAIL unfl_single got=%0b exp=0", a_unfl); end
      checks++; if (a_used !== 4'd0 || a_full !== 1'b0 || a_empty !== 1'b1) begin
         failures++; $display("FAIL unfl_ptrs got=%0d/%0b/%0b exp=0/0/1", a_used, a_full, a_empty);
      end
      for (int n = 1; n <= 6; n++) begin
         wr_word(16'(16'h3300 + n), 1'b0, 1'b0);
         checks++; if (b_used !== 4'(n) || b_amty !== (n <= 2) || b_aful !== (n >= 6)) begin
            failures++; $display("FAIL thr_plain_%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b", n, b_used, b_amty, b_aful, n, (n <= 2), (n >= 6));
         end
         checks++; if (a_aful !== (n >= 6) || a_amty !== 1'b1) begin
            failures++; $display("FAIL thr_pkt_%0d got=%0b/%0b exp=%0b/1", n, a_aful, a_amty, (n >= 6));
         end
      end
   endtask

   task automatic test_plain_mode();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         wr_word(16'(16'h3000 + k), (k == 2 || k == 7), 1'b0);
         if (k < 2) begin
            checks++; if (b_empty !== 1'b1) begin failures++; $display("FAIL plain_lat%0d got=%0b exp=1", k, b_empty); end
         end
         if (k == 2) begin
            checks++; if (b_empty !== 1'b0 || b_dout !== 16'h3000) begin failures++; $display("FAIL plain_first got=%0b/%0h exp=0/3000", b_empty, b_dout); end
         end
      end
      checks++; if (b_pkt !== 4'd2 || b_used !== 4'd8 || b_full !== 1'b1) begin
         failures++; $display("FAIL plain_counts got=%0d/%0d/%0b exp=2/8/1", b_pkt, b_used, b_full);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (b_empty !== 1'b1 || b_used !== 4'd0 || b_pkt !== 4'd0 || b_full !== 1'b0) begin
         failures++; $display("FAIL async_rst got=%0b/%0d/%0d/%0b exp=1/0/0/0", b_empty, b_used, b_pkt, b_full);
      end
      checks++; if (b_dout !== 16'h0 || b_eop !== 1'b0 || a_used !== 4'd0 || a_drop !== 1'b0) begin
         failures++; $display("FAIL async_rst_out got=%0h/%0b/%0d/%0b exp=0/0/0/0", b_dout, b_eop, a_used, a_drop);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_good_pkt();
      test_err_drop();
      test_overflow();
      test_back_to_back();
      test_unfl_thresholds();
      test_plain_mode();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
